// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store requesters.
// Optional round-robin conflict resolution is enabled by defining MEMARB_RR_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            r_state;
  owner_t            r_owner;
  logic [3:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ready;
  logic              r_d_ready;
  logic              w_grant_data;

`ifdef MEMARB_RR_EN
  owner_t r_last_owner;

  // On conflict the requester that did not own the last completed access wins.
  always_comb begin
    w_grant_data = d_req & (~if_req | (r_last_owner == OWN_FETCH));
  end
`else
  always_comb begin
    w_grant_data = d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_FETCH;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
`ifdef MEMARB_RR_EN
      r_last_owner <= OWN_FETCH;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_owner     <= OWN_DATA;
            r_mem_en    <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_cnt       <= LAT_M1;
            r_state     <= S_BUSY;
          end else if (if_req) begin
            r_owner     <= OWN_FETCH;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_cnt       <= LAT_M1;
            r_state     <= S_BUSY;
          end else begin
            r_mem_en <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_owner == OWN_FETCH) begin
              r_if_rdata <= mem_rdata;
              r_if_ready <= 1'b1;
            end else begin
              if (!r_mem_we) r_d_rdata <= mem_rdata;
              r_d_ready <= 1'b1;
            end
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
`ifdef MEMARB_RR_EN
            r_last_owner <= r_owner;
`endif
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_if_ready <= 1'b0;
          r_d_ready  <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;
  assign if_ready    = r_if_ready;
  assign d_ready     = r_d_ready;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign stall_fetch = if_req & ~r_if_ready;
  assign stall_data  = d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MEM_LAT=2 and MEM_LAT=1 instances).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_en, mem_we, stall_fetch, stall_data;

  logic        d1_req;
  logic [15:0] d1_addr, mem1_rdata;
  logic [15:0] if1_rdata, d1_rdata, mem1_addr, mem1_wdata;
  logic        if1_ready, d1_ready, mem1_en, mem1_we, stall1_fetch, stall1_data;

  int n_pass;
  int n_total;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_data(stall_data)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(rst_n),
    .if_req(1'b0), .if_addr(16'h0000), .if_rdata(if1_rdata), .if_ready(if1_ready),
    .d_req(d1_req), .d_we(1'b0), .d_addr(d1_addr), .d_wdata(16'h0000),
    .d_rdata(d1_rdata), .d_ready(d1_ready),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata), .stall_fetch(stall1_fetch), .stall_data(stall1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, ifq;
    logic [15:0] ia;
    logic        dq, dwe;
    logic [15:0] da, dwd, mrd;
    logic        en, we;
    logic [15:0] addr, wd;
    logic        ir, dr;
    logic [15:0] ird, drd;
    logic        sf, sd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic rst, input logic ifq, input logic [15:0] ia,
    input logic dq, input logic dwe, input logic [15:0] da, input logic [15:0] dwd,
    input logic [15:0] mrd, input logic en, input logic we, input logic [15:0] addr,
    input logic [15:0] wd, input logic ir, input logic dr, input logic [15:0] ird,
    input logic [15:0] drd, input logic sf, input logic sd);
    vec_t r;
    r.rst_n = rst; r.ifq = ifq; r.ia = ia; r.dq = dq; r.dwe = dwe; r.da = da;
    r.dwd = dwd; r.mrd = mrd; r.en = en; r.we = we; r.addr = addr; r.wd = wd;
    r.ir = ir; r.dr = dr; r.ird = ird; r.drd = drd; r.sf = sf; r.sd = sd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t r);
    rst_n = r.rst_n; if_req = r.ifq; if_addr = r.ia; d_req = r.dq; d_we = r.dwe;
    d_addr = r.da; d_wdata = r.dwd; mem_rdata = r.mrd;
  endtask

  // Address compared only while enabled, write data only while writing.
  task automatic check_row(input int idx, input vec_t r);
    logic [127:0] act, exp;
    act = {58'd0, mem_en, mem_we, if_ready, d_ready, stall_fetch, stall_data,
           (r.en ? mem_addr : 16'h0), (r.we ? mem_wdata : 16'h0), if_rdata, d_rdata};
    exp = {58'd0, r.en, r.we, r.ir, r.dr, r.sf, r.sd,
           (r.en ? r.addr : 16'h0), (r.we ? r.wd : 16'h0), r.ird, r.drd};
    chk($sformatf("row%0d", idx), act, exp);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    d1_req = 1'b0; d1_addr = '0; mem1_rdata = '0;

    // Fetch read
    vecs.push_back(v(1,1,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5, 0,0,16'h0000,16'h0000,0,0,16'h0000,16'h0000,1,0));
    vecs.push_back(v(1,1,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5, 1,0,16'h0010,16'h0000,0,0,16'h0000,16'h0000,1,0));
    vecs.push_back(v(1,1,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5, 1,0,16'h0010,16'h0000,0,0,16'h0000,16'h0000,1,0));
    vecs.push_back(v(1,1,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5, 0,0,16'h0000,16'h0000,1,0,16'hA5A5,16'h0000,0,0));
    vecs.push_back(v(1,0,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5, 0,0,16'h0000,16'h0000,0,0,16'hA5A5,16'h0000,0,0));
    // Load
    vecs.push_back(v(1,0,16'h0000,1,0,16'h0020,16'h0000,16'hBEEF, 0,0,16'h0000,16'h0000,0,0,16'hA5A5,16'h0000,0,1));
    vecs.push_back(v(1,0,16'h0000,1,0,16'h0020,16'h0000,16'hBEEF, 1,0,16'h0020,16'h0000,0,0,16'hA5A5,16'h0000,0,1));
    vecs.push_back(v(1,0,16'h0000,1,0,16'h0020,16'h0000,16'hBEEF, 1,0,16'h0020,16'h0000,0,0,16'hA5A5,16'h0000,0,1));
    vecs.push_back(v(1,0,16'h0000,1,0,16'h0020,16'h0000,16'hBEEF, 0,0,16'h0000,16'h0000,0,1,16'hA5A5,16'hBEEF,0,0));
    vecs.push_back(v(1,0,16'h0000,0,0,16'h0020,16'h0000,16'hBEEF, 0,0,16'h0000,16'h0000,0,0,16'hA5A5,16'hBEEF,0,0));
    // Store: read data bus carries junk that must not be captured
    vecs.push_back(v(1,0,16'h0000,1,1,16'h0040,16'h1234,16'hFFFF, 0,0,16'h0000,16'h0000,0,0,16'hA5A5,16'hBEEF,0,1));
    vecs.push_back(v(1,0,16'h0000,1,1,16'h0040,16'h1234,16'hFFFF, 1,1,16'h0040,16'h1234,0,0,16'hA5A5,16'hBEEF,0,1));
    vecs.push_back(v(1,0,16'h0000,1,1,16'h0040,16'h1234,16'hFFFF, 1,1,16'h0040,16'h1234,0,0,16'hA5A5,16'hBEEF,0,1));
    vecs.push_back(v(1,0,16'h0000,1,1,16'h0040,16'h1234,16'hFFFF, 0,0,16'h0000,16'h0000,0,1,16'hA5A5,16'hBEEF,0,0));
    vecs.push_back(v(1,0,16'h0000,0,1,16'h0040,16'h1234,16'hFFFF, 0,0,16'h0000,16'h0000,0,0,16'hA5A5,16'hBEEF,0,0));
    // Conflict: both requests in the same IDLE cycle
    vecs.push_back(v(1,1,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,0,0,16'hA5A5,16'hBEEF,1,1));
`ifdef MEMARB_RR_EN
    vecs.push_back(v(1,1,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0100,16'h0000,0,0,16'hA5A5,16'hBEEF,1,1));
    vecs.push_back(v(1,1,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0100,16'h0000,0,0,16'hA5A5,16'hBEEF,1,1));
    vecs.push_back(v(1,1,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,1,0,16'h1111,16'hBEEF,0,1));
    vecs.push_back(v(1,0,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,0,0,16'h1111,16'hBEEF,0,1));
    vecs.push_back(v(1,0,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0200,16'h0000,0,0,16'h1111,16'hBEEF,0,1));
    vecs.push_back(v(1,0,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0200,16'h0000,0,0,16'h1111,16'hBEEF,0,1));
    vecs.push_back(v(1,0,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,0,1,16'h1111,16'h1111,0,0));
`else
    vecs.push_back(v(1,1,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0200,16'h0000,0,0,16'hA5A5,16'hBEEF,1,1));
    vecs.push_back(v(1,1,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0200,16'h0000,0,0,16'hA5A5,16'hBEEF,1,1));
    vecs.push_back(v(1,1,16'h0100,1,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,0,1,16'hA5A5,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0100,0,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,0,0,16'hA5A5,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0100,0,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0100,16'h0000,0,0,16'hA5A5,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0100,0,0,16'h0200,16'h0000,16'h1111, 1,0,16'h0100,16'h0000,0,0,16'hA5A5,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0100,0,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,1,0,16'h1111,16'h1111,0,0));
`endif
    vecs.push_back(v(1,0,16'h0100,0,0,16'h0200,16'h0000,16'h1111, 0,0,16'h0000,16'h0000,0,0,16'h1111,16'h1111,0,0));
    // Back-to-back fetches
    vecs.push_back(v(1,1,16'h0000,0,0,16'h0000,16'h0000,16'h3333, 0,0,16'h0000,16'h0000,0,0,16'h1111,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0000,0,0,16'h0000,16'h0000,16'h3333, 1,0,16'h0000,16'h0000,0,0,16'h1111,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0000,0,0,16'h0000,16'h0000,16'h3333, 1,0,16'h0000,16'h0000,0,0,16'h1111,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0000,0,0,16'h0000,16'h0000,16'h3333, 0,0,16'h0000,16'h0000,1,0,16'h3333,16'h1111,0,0));
    vecs.push_back(v(1,1,16'h0001,0,0,16'h0000,16'h0000,16'h4444, 0,0,16'h0000,16'h0000,0,0,16'h3333,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0001,0,0,16'h0000,16'h0000,16'h4444, 1,0,16'h0001,16'h0000,0,0,16'h3333,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0001,0,0,16'h0000,16'h0000,16'h4444, 1,0,16'h0001,16'h0000,0,0,16'h3333,16'h1111,1,0));
    vecs.push_back(v(1,1,16'h0001,0,0,16'h0000,16'h0000,16'h4444, 0,0,16'h0000,16'h0000,1,0,16'h4444,16'h1111,0,0));
    vecs.push_back(v(1,0,16'h0001,0,0,16'h0000,16'h0000,16'h4444, 0,0,16'h0000,16'h0000,0,0,16'h4444,16'h1111,0,0));

    // Reset state
    next_cycle();
    @(negedge clk);
    chk("reset_state", {mem_en, mem_we, if_ready, d_ready, mem_addr, mem_wdata, if_rdata, d_rdata},
        {4'b0000, 64'h0});
    chk("reset_state_lat1", {mem1_en, mem1_we, if1_ready, d1_ready, mem1_addr, d1_rdata},
        {4'b0000, 32'h0});

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      next_cycle();
      drive(vecs[i]);
      @(negedge clk);
      check_row(int'(i), vecs[i]);
    end

    // Reset during the second BUSY cycle of a load aborts it
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030; mem_rdata = 16'h9999;
    @(negedge clk);
    chk("abort_c0_en", {15'd0, mem_en}, 16'h0000);
    next_cycle();
    @(negedge clk);
    chk("abort_c1_en_addr", {15'd0, mem_en, mem_addr}, {16'h0001, 16'h0030});
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_c2_busy", {14'd0, mem_en, d_ready}, 16'h0002);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_c3_cleared", {14'd0, mem_en, d_ready, d_rdata, if_rdata}, 48'h0);
    next_cycle();
    @(negedge clk);
    chk("abort_regrant_en", {15'd0, mem_en, mem_addr}, {16'h0001, 16'h0030});
    next_cycle();
    @(negedge clk);
    chk("abort_regrant_busy", {14'd0, mem_en, d_ready}, 16'h0002);
    next_cycle();
    @(negedge clk);
    chk("abort_regrant_ready", {14'd0, mem_en, d_ready, d_rdata}, {16'h0001, 16'h9999});
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk("abort_regrant_idle", {14'd0, mem_en, d_ready}, 16'h0000);

    // MEM_LAT=1 load on the second instance
    next_cycle();
    d1_req = 1'b1; d1_addr = 16'h0055; mem1_rdata = 16'h7777;
    @(negedge clk);
    chk("lat1_c0", {13'd0, mem1_en, d1_ready, stall1_data}, 16'h0001);
    next_cycle();
    @(negedge clk);
    chk("lat1_c1", {13'd0, mem1_en, d1_ready, stall1_data, mem1_addr}, {16'h0005, 16'h0055});
    next_cycle();
    @(negedge clk);
    chk("lat1_c2", {13'd0, mem1_en, d1_ready, stall1_data, d1_rdata}, {16'h0002, 16'h7777});
    next_cycle();
    d1_req = 1'b0;
    @(negedge clk);
    chk("lat1_c3", {13'd0, mem1_en, d1_ready, stall1_data, d1_rdata}, {16'h0000, 16'h7777});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified 16-bit memory between two requesters: the instruction fetch path (IF stage) and the load/store data path (MEM stage).
- Sequences each access over a fixed, parameterised memory latency.
- Returns read data and a one-cycle ready pulse to the requester.
- Drives stall outputs that the pipeline ORs into its existing stall logic.

Parameters:
- ADDR_W, 16, address width for both requesters and the memory port.
- DATA_W, 16, data width.
- MEM_LAT, 2, cycles the memory needs to hold a request. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction word (registered)
- if_ready  out  1  one-cycle pulse: fetch complete
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data (registered)
- d_ready  out  1  one-cycle pulse: data access complete
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last BUSY cycle
- stall_fetch  out  1  combinational: if_req & ~if_ready
- stall_data  out  1  combinational: d_req & ~d_ready

Behaviour:
- Reset (reset_n=0 at a posedge):
  - state=IDLE, owner=FETCH, cnt=0.
  - mem_en, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata all 0.
  - Reset in BUSY or RESP aborts the access: no ready pulse, mem_en low from the next cycle.
- FSM states: IDLE, BUSY, RESP. Grants are made only in IDLE.
- IDLE:
  - Requests are sampled at the posedge.
  - d_req=1: grant DATA (fixed priority, data wins over fetch).
  - Else if_req=1: grant FETCH.
  - On grant: owner latched; mem_en=1; mem_addr, mem_we (d_we for DATA, 0 for FETCH) and mem_wdata registered; cnt=MEM_LAT-1; next state BUSY.
  - No request: stay IDLE, mem_en=0.
- BUSY:
  - mem_* held stable.
  - cnt>0: cnt decrements.
  - cnt==0: at the posedge, mem_rdata is captured into the owner's rdata (loads and fetches only). mem_en and mem_we drop to 0, the owner's ready is set, next state RESP.
  - Store: d_rdata unchanged.
- RESP: the owner's ready is high for exactly this cycle; next state IDLE.
- Latency:
  - Request asserted in cycle 0 (IDLE) gives mem_en high in cycles 1..MEM_LAT and ready in cycle MEM_LAT+1.
  - Throughput is one access per MEM_LAT+2 cycles.
- Requester rules:
  - req, addr, we and wdata must be stable from assertion until ready.
  - A req dropped mid-access does not cancel it; the access completes and ready still pulses.
  - The non-owner request waits and is evaluated at the next IDLE.
- Simultaneous events:
  - Both requests in IDLE: DATA first.
  - A request arriving during the other's RESP is granted at the following IDLE cycle.
  - if_ready and d_ready are never high together.
- Stalls: stall_fetch and stall_data are purely combinational and are high on the cycle a request is first asserted.

Optional Feature:
- Macro: MEMARB_RR_EN.
- Defined:
  - A last_owner flag (reset value FETCH) records the owner of each completed access.
  - When both request in IDLE, the requester not equal to last_owner is granted (round-robin). The first conflict after reset still goes to DATA.
- Undefined: fixed data priority as above; no last_owner flop.

Test Plan:
- Fetch read, MEM_LAT=2: if_req=1, if_addr=0x0010 in cycle 0; memory returns 0xA5A5 → mem_en=1, mem_we=0, mem_addr=0x0010 in cycles 1-2; if_ready=1 in cycle 3 only; if_rdata=0xA5A5; stall_fetch=1 in cycles 0-2.
- Store: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234 → mem_we=1, mem_wdata=0x1234 in cycles 1-2; d_ready in cycle 3; d_rdata keeps its prior value.
- Conflict: if_req and d_req both high in cycle 0 → d_ready in cycle 3, fetch granted cycle 4, if_ready in cycle 7. With MEMARB_RR_EN and a previous DATA access, the order is reversed (if_ready cycle 3, d_ready cycle 7).
- Back-to-back: if_req held high with two addresses 0x0000 then 0x0001 → ready pulses in cycles 3 and 7; mem_en low in cycles 3-4.
- Reset mid-access: reset_n=0 in cycle 2 of a load → mem_en=0 from cycle 3; no d_ready; d_rdata=0; a new d_req is granted once reset_n=1.
- MEM_LAT=1: a single load gives mem_en only in cycle 1 and d_ready in cycle 2.
